// File: rtl/regbank_alu_sequencer.sv
// Multi-cycle sequencer for register/immediate ALU instructions: decodes one
// instruction, steers the operand muxes and ALU, captures the result and flags, then writes back.
module regbank_alu_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 16,
    parameter int MAX_ALU_REG = 12,
    parameter int FLAG_W      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                busy,
    output logic [4:0]          sel_a,
    output logic [4:0]          sel_b,
    output logic                use_imm,
    output logic [DATA_W-1:0]   imm_ext,
    output logic [3:0]          alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic [NUM_REGS-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic [FLAG_W-1:0]   flags,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_ERR
    } state_t;

    localparam logic [3:0] CODE_ADD = 4'b0101;
    localparam logic [3:0] CODE_SUB = 4'b1001;
    localparam logic [3:0] CODE_CMP = 4'b1011;
    localparam logic [3:0] CODE_AND = 4'b0001;
    localparam logic [3:0] CODE_OR  = 4'b0010;
    localparam logic [3:0] CODE_XOR = 4'b0011;
    localparam logic [3:0] CODE_MOV = 4'b1101;
    localparam logic [3:0] MAX_IDX  = 4'(MAX_ALU_REG);

    state_t              state_q, state_d;
    logic [3:0]          code_q, code_d;
    logic [3:0]          rdest_q, rdest_d;
    logic [3:0]          rsrc_q, rsrc_d;
    logic                use_imm_q, use_imm_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    // Combinational decode of the incoming instruction, consumed only on accept.
    logic                is_reg_w;
    logic [3:0]          code_w;
    logic                known_w;
    logic                zext_w;
    logic                legal_w;
    logic [DATA_W-1:0]   imm_w;

    always_comb begin
        is_reg_w = (instr[15:12] == 4'b0000);
        code_w   = is_reg_w ? instr[7:4] : instr[15:12];
        known_w  = 1'b0;
        zext_w   = 1'b0;
        case (code_w)
            CODE_ADD, CODE_SUB, CODE_CMP, CODE_MOV: known_w = 1'b1;
            CODE_AND, CODE_OR, CODE_XOR: begin
                known_w = 1'b1;
                zext_w  = 1'b1;
            end
            default: known_w = 1'b0;
        endcase
        if (is_reg_w) begin
            imm_w = '0;
        end else if (zext_w) begin
            imm_w = {{(DATA_W-8){1'b0}}, instr[7:0]};
        end else begin
            imm_w = {{(DATA_W-8){instr[7]}}, instr[7:0]};
        end
        // r13..r15 are architectural (PC/ISP/INTBASE) and never ALU operands.
        legal_w = known_w && (instr[11:8] <= MAX_IDX) &&
                  (!is_reg_w || (instr[3:0] <= MAX_IDX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            rdest_q   <= '0;
            rsrc_q    <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            wr_data_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            rdest_q   <= rdest_d;
            rsrc_q    <= rsrc_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            wr_data_q <= wr_data_d;
            flags_q   <= flags_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        rdest_d   = rdest_q;
        rsrc_d    = rsrc_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        wr_data_d = wr_data_q;
        flags_d   = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    code_d    = code_w;
                    rdest_d   = instr[11:8];
                    rsrc_d    = is_reg_w ? instr[3:0] : 4'd0;
                    use_imm_d = !is_reg_w;
                    imm_d     = imm_w;
                    state_d   = legal_w ? ST_READ : ST_ERR;
                end
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: begin
                wr_data_d = alu_result;
                if (code_q == CODE_ADD || code_q == CODE_SUB || code_q == CODE_CMP) begin
                    flags_d = alu_flags;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    logic operand_phase;
    logic write_phase;

    always_comb begin
        operand_phase = (state_q == ST_READ) || (state_q == ST_EXEC);
        write_phase   = (state_q == ST_WRITE) && (code_q != CODE_CMP);
        instr_ready   = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        sel_a         = operand_phase ? {1'b0, rdest_q} : 5'd0;
        sel_b         = operand_phase ? {1'b0, rsrc_q} : 5'd0;
        use_imm       = operand_phase && use_imm_q;
        imm_ext       = operand_phase ? imm_q : '0;
        alu_op        = operand_phase ? code_q : 4'd0;
        done          = (state_q == ST_WRITE) || (state_q == ST_ERR);
        err           = (state_q == ST_ERR);
        wr_data       = wr_data_q;
        flags         = flags_q;
    end

    // Protected registers get no write-enable decode at all, so they stay dark by construction.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
            if (gi <= MAX_ALU_REG) begin : g_legal
                assign wr_en[gi] = write_phase && (rdest_q == 4'(gi));
            end else begin : g_protected
                assign wr_en[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regbank_alu_sequencer.sv
// Randomized and directed bench for regbank_alu_sequencer against a behavioural decode/state model.
module tb_regbank_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic        use_imm;
    logic [15:0] imm_ext;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;
    logic [15:0] wr_en;
    logic [15:0] wr_data;
    logic [4:0]  flags;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [4:0]  flags_m = '0;
    logic [15:0] wd_m    = '0;
    bit          mon_en  = 1'b0;
    logic        prev_done = 1'b0;

    regbank_alu_sequencer dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .sel_a(sel_a), .sel_b(sel_b),
        .use_imm(use_imm), .imm_ext(imm_ext), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags), .wr_en(wr_en),
        .wr_data(wr_data), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural instruction meaning, straight from the encoding rules.
    function automatic void ref_decode(input logic [15:0] ins, output bit legal,
                                       output logic [3:0] code, output logic [4:0] sa,
                                       output logic [4:0] sb, output bit imm_form,
                                       output logic [15:0] imm, output logic [15:0] wre,
                                       output bit flag_op);
        int rd, rs, s;
        rd       = int'(ins[11:8]);
        rs       = int'(ins[3:0]);
        imm_form = (ins[15:12] != 4'd0);
        code     = imm_form ? ins[15:12] : ins[7:4];
        legal    = (code inside {4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3, 4'd13}) &&
                   rd <= 12 && (imm_form || rs <= 12);
        sa       = 5'(rd);
        sb       = imm_form ? 5'd0 : 5'(rs);
        if (!imm_form) begin
            imm = 16'd0;
        end else if (code inside {4'd1, 4'd2, 4'd3}) begin
            imm = 16'(int'(ins[7:0]));
        end else begin
            s   = (int'(ins[7:0]) >= 128) ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
            imm = 16'(s);
        end
        flag_op = code inside {4'd5, 4'd9, 4'd11};
        wre     = (code == 4'd11) ? 16'd0 : 16'(1 << rd);
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge where it is idle again.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] res,
                             input logic [4:0] fl, input bit hold);
        bit legal, imm_form, flag_op;
        logic [3:0] code;
        logic [4:0] sa, sb;
        logic [15:0] imm, wre;
        int w;
        ref_decode(ins, legal, code, sa, sb, imm_form, imm, wre, flag_op);
        w = 0;
        while (instr_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_val("ready_idle", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
        instr      = 16'($urandom);
        alu_result = 16'($urandom);
        alu_flags  = 5'($urandom);
        check_val("busy", 32'(busy), 32'd1);
        check_val("ready_busy", 32'(instr_ready), 32'd0);
        if (legal) begin
            check_val("done_read", 32'(done), 32'd0);
            check_val("sel_a", 32'(sel_a), 32'(sa));
            check_val("sel_b", 32'(sel_b), 32'(sb));
            check_val("use_imm", 32'(use_imm), 32'(imm_form));
            check_val("imm_ext", 32'(imm_ext), 32'(imm));
            check_val("alu_op", 32'(alu_op), 32'(code));
            @(negedge clk);
            check_val("sel_a_exec", 32'(sel_a), 32'(sa));
            check_val("alu_op_exec", 32'(alu_op), 32'(code));
            check_val("wr_en_exec", 32'(wr_en), 32'd0);
            alu_result = res;
            alu_flags  = fl;
            @(negedge clk);
            alu_result = ~res;
            wd_m = res;
            if (flag_op) flags_m = fl;
            check_val("wr_en", 32'(wr_en), 32'(wre));
            check_val("done_wr", 32'(done), 32'd1);
            check_val("err_wr", 32'(err), 32'd0);
            check_val("wr_data", 32'(wr_data), 32'(wd_m));
            check_val("flags", 32'(flags), 32'(flags_m));
            @(negedge clk);
            check_val("done_idle", 32'(done), 32'd0);
            check_val("busy_idle", 32'(busy), 32'd0);
            check_val("sel_a_idle", 32'(sel_a), 32'd0);
            check_val("alu_op_idle", 32'(alu_op), 32'd0);
            check_val("imm_idle", 32'(imm_ext), 32'd0);
            check_val("wr_data_hold", 32'(wr_data), 32'(wd_m));
        end else begin
            check_val("done_err", 32'(done), 32'd1);
            check_val("err", 32'(err), 32'd1);
            check_val("wr_en_err", 32'(wr_en), 32'd0);
            check_val("sel_a_err", 32'(sel_a), 32'd0);
            check_val("alu_op_err", 32'(alu_op), 32'd0);
            check_val("flags_err", 32'(flags), 32'(flags_m));
            @(negedge clk);
            check_val("done_after_err", 32'(done), 32'd0);
            check_val("err_after", 32'(err), 32'd0);
            check_val("wr_data_err", 32'(wr_data), 32'(wd_m));
            check_val("flags_after_err", 32'(flags), 32'(flags_m));
        end
        $display("instr %h res=%h fl=%b legal=%0d hold=%0d", ins, res, fl, legal, hold);
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check_val("wr_en_onehot", 32'($countones(wr_en) <= 1), 32'd1);
            check_val("wr_en_prot", 32'(wr_en[15:13]), 32'd0);
            check_val("done_pair", 32'(prev_done && done), 32'd0);
            check_val("ready_vs_busy", 32'(instr_ready ^ busy), 32'd1);
        end
        prev_done = done;
    end

    logic [3:0] codes [7] = '{4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3, 4'd13};

    initial begin
        logic [3:0] c, rd;
        logic [15:0] ins;
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        alu_result  = '0;
        alu_flags   = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(instr_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_flags", 32'(flags), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_done", 32'(done | err), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_instr(16'h0152, 16'h0007, 5'b00010, 1'b0);  // ADD r1,r2
        run_instr(16'h94FF, 16'h1111, 5'b10001, 1'b0);  // SUBI r4,#-1
        run_instr(16'h1480, 16'h0080, 5'b01100, 1'b0);  // ANDI r4,#0x80
        run_instr(16'h03B5, 16'hABCD, 5'b00101, 1'b0);  // CMP r3,r5
        run_instr(16'h0D51, 16'h5555, 5'b11111, 1'b0);
        run_instr(16'h015E, 16'h5555, 5'b11111, 1'b0);
        run_instr(16'h0172, 16'h5555, 5'b11111, 1'b0);
        run_instr(16'hD0F0, 16'hFFF0, 5'b11011, 1'b0);  // MOVI r0,#-16

        // Valid held high across busy periods.
        run_instr(16'h0152, 16'h0102, 5'b00001, 1'b1);
        run_instr(16'h0C3A, 16'h0304, 5'b00011, 1'b1);
        run_instr(16'h2C7F, 16'h0506, 5'b00111, 1'b1);
        instr_valid = 1'b0;

        // Reset while MOV r6,r7 is in EXEC.
        instr = 16'h06D7;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check_val("mov_op", 32'(alu_op), 32'd13);
        @(negedge clk);
        alu_result = 16'h1234;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        flags_m = '0;
        wd_m = '0;
        check_val("abort_wr_en", 32'(wr_en), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_ready", 32'(instr_ready), 32'd1);
        check_val("abort_wr_data", 32'(wr_data), 32'd0);
        check_val("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        check_val("abort_wr_en2", 32'(wr_en), 32'd0);
        check_val("abort_ready2", 32'(instr_ready), 32'd1);
        check_val("abort_alu_op", 32'(alu_op), 32'd0);
        $display("instr 06d7 aborted by reset in EXEC");

        for (int i = 0; i < 150; i++) begin
            c  = ($urandom_range(0, 4) != 0) ? codes[$urandom_range(0, 6)] : 4'($urandom);
            rd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                ins = {4'd0, rd, c, 4'($urandom_range(0, 15))};
            else
                ins = {c, rd, 8'($urandom)};
            run_instr(ins, 16'($urandom), 5'($urandom), bit'($urandom_range(0, 1)));
        end
        instr_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
